fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Instruction-fetch front end of the pipelined core. It holds the program counter, drives the instruction-memory address, and supplies the sequential next address (PC + increment) to the adder stage. It selects the next PC among sequential, branch, jump and jump-register targets, and captures the fetched word into the IF/ID pipeline register with stall, flush and halt handling.

## Interface
Parameters:
- `NBITS`, 32, datapath / address width
- `RESET_PC`, 0, PC value after reset
- `PC_INC`, 4, byte increment per instruction
- `HALT_OPCODE`, 6'b111111, opcode (`instr[31:26]`) that halts fetch

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `i_enable`  in  1  global run enable from debug unit
- `i_stall`  in  1  hazard unit: hold PC and IF/ID
- `i_flush`  in  1  load a bubble into IF/ID
- `i_pc_src`  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 jump-register
- `i_branch_target`, `i_jump_target`, `i_jr_target`  in  NBITS  redirect targets
- `i_instr`  in  NBITS  instruction-memory read data (async read of `o_pc`)
- `o_pc`  out  NBITS  registered PC / imem address
- `o_pc_plus_inc`  out  NBITS  combinational `o_pc + PC_INC`
- `o_ifid_instr`  out  NBITS  IF/ID instruction
- `o_ifid_pc_plus_inc`  out  NBITS  IF/ID sequential address
- `o_ifid_valid`  out  1  IF/ID holds a real instruction
- `o_halted`  out  1  fetch is halted
- `i_step`  in  1  single-step pulse (only with `FETCH_STEP_EN`)

## Operation
- States: RUN, HALTED. Reset enters RUN. HALTED is left only by reset.
- `adv` = state==RUN & enable_term & !i_stall. Without the macro, enable_term = `i_enable`.
- On `adv`, the next PC is selected by `i_pc_src`:
  - 00: `o_pc_plus_inc`
  - 01: `i_branch_target`
  - 10: `i_jump_target`
  - 11: `i_jr_target`
- On `adv` & !`i_flush`, IF/ID loads {`i_instr`, `o_pc_plus_inc`, valid=1}.
- On `i_flush`, IF/ID loads a bubble {0, 0, valid=0}. This applies in any state and also with `i_stall`: flush beats stall for IF/ID, while the PC still holds.
- With `i_stall` & !`i_flush`, PC and IF/ID hold. A redirect (`i_pc_src`≠00) presented during a stall is dropped. The hazard unit must not issue one; the bench flags it.
- Halt detection:
  - Condition: `adv` & !`i_flush` & `i_instr[31:26]`==`HALT_OPCODE`.
  - IF/ID captures the halt word with valid=1.
  - PC is not updated and stays at the halt address.
  - State moves to HALTED.
  - A halt word fetched in a flush cycle is discarded; state stays RUN.
- In HALTED: PC frozen; IF/ID loads a bubble each cycle, so the halt reaches the pipeline exactly once; `o_halted`=1.
- With `i_enable`=0 (and no step): PC and IF/ID hold. Flush still applies.
- Arithmetic: `o_pc_plus_inc` is computed modulo 2^NBITS. 0xFFFFFFFC + 4 wraps to 0. Targets are used unmodified; no alignment check.

## Timing
- Reset values:
  - `o_pc`=RESET_PC
  - `o_ifid_instr`=0
  - `o_ifid_pc_plus_inc`=0
  - `o_ifid_valid`=0
  - `o_halted`=0
  - `o_pc_plus_inc`=RESET_PC+PC_INC
- Reset mid-operation, including in HALTED, returns immediately (asynchronously) to these values.
- Fetch latency: a word at address A appears on IF/ID one edge after `o_pc`=A with `adv`.
- Redirect: the target appears on `o_pc` one edge after the `adv` cycle that selects it.
- `o_halted` rises one edge after the halt-fetch cycle.
- `o_pc_plus_inc` tracks `o_pc` in the same cycle (zero latency).

## Configuration
- `FETCH_STEP_EN` defined:
  - Port `i_step` exists.
  - enable_term = `i_enable` | (`i_step` & step_armed).
  - step_armed clears on the step cycle and re-arms once `i_step` is low.
  - A held-high `i_step` therefore advances exactly one instruction.
- Undefined: no `i_step` port; enable_term = `i_enable`.

## Test plan
- Reset, `i_enable`=1, `i_pc_src`=00, imem returns NOPs -> `o_pc` 0,4,8,12 on successive edges; IF/ID valid from second edge with `pc_plus_inc` 4,8,12.
- `i_stall` high 3 cycles at `o_pc`=8 -> `o_pc`=8 and IF/ID unchanged for 3 edges; resumes at 12.
- `i_pc_src`=01, `i_branch_target`=0x40, `i_flush`=1 at `o_pc`=0x10 -> next `o_pc`=0x40, IF/ID bubble (valid=0); then the word at 0x40 is captured with `pc_plus_inc`=0x44.
- `i_stall`=1 & `i_flush`=1 together -> PC holds, IF/ID valid=0.
- Halt word (0xFC000000) at 0x20 -> IF/ID holds the halt with valid=1 once, then bubbles; `o_pc` stays 0x20; `o_halted`=1; asserting `rst_n`=0 clears to reset values.
- `RESET_PC`=0xFFFFFFFC -> `o_pc_plus_inc`=0, next `o_pc`=0. With `FETCH_STEP_EN`, `i_enable`=0 and `i_step` held high 5 cycles -> exactly one PC advance.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end.
// Holds the PC, drives the imem address, selects the next PC
// (sequential / branch / jump / jump-register) and fills the IF/ID register
// with stall, flush and halt handling.
// Optional feature macro: FETCH_STEP_EN adds the i_step single-step input.
module fetch_pc_unit #(
    parameter int unsigned      NBITS       = 32,
    parameter logic [NBITS-1:0] RESET_PC    = '0,
    parameter int unsigned      PC_INC      = 4,
    parameter logic [5:0]       HALT_OPCODE = 6'b111111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic [1:0]       i_pc_src,
    input  logic [NBITS-1:0] i_branch_target,
    input  logic [NBITS-1:0] i_jump_target,
    input  logic [NBITS-1:0] i_jr_target,
    input  logic [NBITS-1:0] i_instr,
    output logic [NBITS-1:0] o_pc,
    output logic [NBITS-1:0] o_pc_plus_inc,
    output logic [NBITS-1:0] o_ifid_instr,
    output logic [NBITS-1:0] o_ifid_pc_plus_inc,
    output logic             o_ifid_valid,
    output logic             o_halted
`ifdef FETCH_STEP_EN
    ,
    input  logic             i_step
`endif
);

    localparam logic [NBITS-1:0] PC_INC_W = NBITS'(PC_INC);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state_q;
    logic [NBITS-1:0] pc_q;
    logic [NBITS-1:0] ifid_instr_q;
    logic [NBITS-1:0] ifid_ppi_q;
    logic             ifid_valid_q;
    logic             halted_q;

    logic [NBITS-1:0] pc_plus_inc;
    logic [NBITS-1:0] pc_d;
    logic             enable_term;
    logic             adv;
    logic             halt_fetch;

`ifdef FETCH_STEP_EN
    logic step_armed_q;

    assign enable_term = i_enable | (i_step & step_armed_q);

    // Step arming: disarm once a step has advanced fetch, re-arm when i_step drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_armed_q <= 1'b1;
        end else if (!i_step) begin
            step_armed_q <= 1'b1;
        end else if (step_armed_q && adv) begin
            step_armed_q <= 1'b0;
        end
    end
`else
    assign enable_term = i_enable;
`endif

    assign pc_plus_inc = pc_q + PC_INC_W;
    assign adv         = (state_q == RUN) & enable_term & ~i_stall;
    assign halt_fetch  = adv & ~i_flush & (i_instr[31:26] == HALT_OPCODE);

    // Next-PC selection among sequential and redirect targets
    always_comb begin
        pc_d = pc_plus_inc;
        case (i_pc_src)
            2'b00:   pc_d = pc_plus_inc;
            2'b01:   pc_d = i_branch_target;
            2'b10:   pc_d = i_jump_target;
            default: pc_d = i_jr_target;
        endcase
    end

    // Fetch FSM: PC, IF/ID register and halt state, all registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_ppi_q   <= '0;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    // The halt word is captured but the PC stays on it
                    if (adv && !halt_fetch) begin
                        pc_q <= pc_d;
                    end
                    // Flush wins over both stall and advance for IF/ID
                    if (i_flush) begin
                        ifid_instr_q <= '0;
                        ifid_ppi_q   <= '0;
                        ifid_valid_q <= 1'b0;
                    end else if (adv) begin
                        ifid_instr_q <= i_instr;
                        ifid_ppi_q   <= pc_plus_inc;
                        ifid_valid_q <= 1'b1;
                    end
                    if (halt_fetch) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    ifid_instr_q <= '0;
                    ifid_ppi_q   <= '0;
                    ifid_valid_q <= 1'b0;
                    halted_q     <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign o_pc               = pc_q;
    assign o_pc_plus_inc      = pc_plus_inc;
    assign o_ifid_instr       = ifid_instr_q;
    assign o_ifid_pc_plus_inc = ifid_ppi_q;
    assign o_ifid_valid       = ifid_valid_q;
    assign o_halted           = halted_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a behavioural fetch model predicts the
// post-edge state, a monitor compares it against the DUT on each falling edge.
module tb_fetch_pc_unit;

    localparam logic [5:0] HALT_OP = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, stall, flush;
    logic [1:0]  src;
    logic [31:0] bt, jt, jrt;
    logic [31:0] instr, instr_w;
    logic [31:0] pc, ppi, ii, ip;
    logic        iv, hl;
    logic [31:0] pc_w, ppi_w, ii_w, ip_w;
    logic        iv_w, hl_w;
`ifdef FETCH_STEP_EN
    logic        step;
`endif

    logic [31:0] halt_addr;
    logic [25:0] salt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ii;
        logic [31:0] ip;
        logic        v;
        logic        h;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc, m_ii, m_ip;
    logic        m_v, m_h, m_armed;

    always #5 clk = ~clk;

    // Instruction memory: an address-derived word, or the halt word at halt_addr
    function automatic logic [31:0] imem(input logic [31:0] a, input logic [31:0] ha,
                                         input logic [25:0] s);
        logic [5:0] opc;
        if (a == ha) return 32'hFC00_0000;
        opc = a[7:2];
        if (opc == HALT_OP) opc = 6'h01;
        return {opc, a[25:0] ^ s};
    endfunction

    always_comb instr   = imem(pc, halt_addr, salt);
    always_comb instr_w = imem(pc_w, halt_addr, salt);

    fetch_pc_unit #(.NBITS(32), .RESET_PC(32'h0), .PC_INC(4), .HALT_OPCODE(6'b111111)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(en), .i_stall(stall), .i_flush(flush),
        .i_pc_src(src), .i_branch_target(bt), .i_jump_target(jt), .i_jr_target(jrt),
        .i_instr(instr), .o_pc(pc), .o_pc_plus_inc(ppi), .o_ifid_instr(ii),
        .o_ifid_pc_plus_inc(ip), .o_ifid_valid(iv), .o_halted(hl)
`ifdef FETCH_STEP_EN
        , .i_step(step)
`endif
    );

    fetch_pc_unit #(.NBITS(32), .RESET_PC(32'hFFFF_FFFC), .PC_INC(4), .HALT_OPCODE(6'b111111)) dut_w (
        .clk(clk), .rst_n(rst_n), .i_enable(en), .i_stall(stall), .i_flush(flush),
        .i_pc_src(src), .i_branch_target(bt), .i_jump_target(jt), .i_jr_target(jrt),
        .i_instr(instr_w), .o_pc(pc_w), .o_pc_plus_inc(ppi_w), .o_ifid_instr(ii_w),
        .o_ifid_pc_plus_inc(ip_w), .o_ifid_valid(iv_w), .o_halted(hl_w)
`ifdef FETCH_STEP_EN
        , .i_step(step)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.pc = m_pc; e.ii = m_ii; e.ip = m_ip; e.v = m_v; e.h = m_h;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ii = '0; m_ip = '0; m_v = 1'b0; m_h = 1'b0; m_armed = 1'b1;
    endtask

    // One clock edge of the fetch unit as described behaviourally
    task automatic model_step();
        logic        go, halt_now, step_in;
        logic [31:0] word, seq;
        if (!rst_n) begin
            model_reset();
            return;
        end
        step_in = 1'b0;
`ifdef FETCH_STEP_EN
        step_in = step;
`endif
        go       = !m_h && (en || (step_in && m_armed)) && !stall;
        word     = imem(m_pc, halt_addr, salt);
        seq      = m_pc + 32'd4;
        halt_now = go && !flush && (word[31:26] == HALT_OP);
        if (flush || m_h) begin
            m_ii = '0; m_ip = '0; m_v = 1'b0;
        end else if (go) begin
            m_ii = word; m_ip = seq; m_v = 1'b1;
        end
        if (go) begin
            if (halt_now) m_h = 1'b1;
            else if (src == 2'b01) m_pc = bt;
            else if (src == 2'b10) m_pc = jt;
            else if (src == 2'b11) m_pc = jrt;
            else m_pc = seq;
        end
        if (!step_in) m_armed = 1'b1;
        else if (go && m_armed) m_armed = 1'b0;
    endtask

    // Advance one edge; the expectation for the new state is queued
    task automatic cycle();
        @(posedge clk);
        model_step();
        sb.push_back(snap());
        #1;
    endtask

    // Asynchronous reset mid-cycle: the pending expectation becomes the reset state
    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        if (sb.size() > 0) sb[sb.size()-1] = snap();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic run_until_pc(input logic [31:0] a);
        int n = 0;
        while (m_pc != a && n < 64) begin
            cycle();
            n++;
        end
        chk("reach_pc", m_pc, a);
    endtask

    // Monitor: compare each queued expectation on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("o_pc", pc, e.pc);
            chk("o_pc_plus_inc", ppi, e.pc + 32'd4);
            chk("ifid_instr", ii, e.ii);
            chk("ifid_pc_plus_inc", ip, e.ip);
            chk("ifid_valid", {31'd0, iv}, {31'd0, e.v});
            chk("halted", {31'd0, hl}, {31'd0, e.h});
        end
        if (rst_n && stall && src != 2'b00) begin
            failures++;
            $display("FAIL redirect_during_stall actual=%b expected=00", src);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; stall = 1'b0; flush = 1'b0; src = 2'b00;
        bt = '0; jt = '0; jrt = '0;
`ifdef FETCH_STEP_EN
        step = 1'b0;
`endif
        halt_addr = 32'hFFFF_0000;
        salt = 26'($urandom);
        model_reset();
        #1;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Wrap-around instance: reset values, then one sequential advance
        @(negedge clk);
        #1;
        chk("wrap_reset_pc", pc_w, 32'hFFFF_FFFC);
        chk("wrap_reset_ppi", ppi_w, 32'h0);
        cycle();
        @(negedge clk);
        #1;
        chk("wrap_next_pc", pc_w, 32'h0);
        chk("wrap_next_ppi", ppi_w, 32'h4);

        // Sequential fetch, then a 3-cycle stall at 8
        run_until_pc(32'h8);
        stall = 1'b1;
        repeat (3) cycle();
        stall = 1'b0;
        cycle();
        chk("resume_pc", m_pc, 32'hC);

        // Branch with flush at 0x10, then the word at 0x40
        run_until_pc(32'h10);
        src = 2'b01; bt = 32'h40; flush = 1'b1;
        cycle();
        src = 2'b00; flush = 1'b0;
        cycle();
        chk("branch_ifid_ppi", m_ip, 32'h44);

        // Stall and flush together
        stall = 1'b1; flush = 1'b1;
        cycle();
        stall = 1'b0; flush = 1'b0;
        cycle();

        // Halt at 0x20 reached by a jump, then reset while halted
        halt_addr = 32'h20;
        src = 2'b10; jt = 32'h18;
        cycle();
        src = 2'b00;
        repeat (6) cycle();
        chk("halt_pc", m_pc, 32'h20);
        chk("halt_flag", {31'd0, m_h}, 32'd1);
        async_reset();
        repeat (2) cycle();

`ifdef FETCH_STEP_EN
        // Single step: held-high i_step advances exactly one instruction
        begin
            logic [31:0] pc0;
            en = 1'b0;
            cycle();
            pc0 = pc;
            step = 1'b1;
            repeat (5) cycle();
            step = 1'b0;
            cycle();
            chk("step_one_advance", pc, pc0 + 32'd4);
            en = 1'b1;
        end
`endif

        // Randomised traffic with occasional halts and resets
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            src   = stall ? 2'b00 : 2'($urandom_range(0, 3));
            bt    = {24'd0, 6'($urandom), 2'b00};
            jt    = {24'd0, 6'($urandom), 2'b00};
            jrt   = {24'd0, 6'($urandom), 2'b00};
`ifdef FETCH_STEP_EN
            step  = ($urandom_range(0, 3) == 0);
`endif
            cycle();
            if ((m_h && $urandom_range(0, 5) == 0) || $urandom_range(0, 99) == 0) begin
                async_reset();
            end
        end

        en = 1'b1; stall = 1'b0; flush = 1'b0; src = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
